dense_accumulator: RTL and testbench
====================================

DENSE_ACCUMULATOR -- requirements
Module: dense_accumulator

Interface
REQ-001 SHALL have parameter BIT_DATA, default 8: operand width of the upstream dense kernel.
REQ-002 SHALL have parameter KSIZE, default 4: lanes (neurons) per beat.
REQ-003 SHALL have parameter BIT_ACC, default 20: signed accumulator width per lane, with BIT_ACC >= 2*BIT_DATA.
REQ-004 SHALL have parameter N_IN, default 4: beats per output vector, with N_IN >= 1.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port y, input, 2*BIT_DATA*KSIZE bits: packed signed products; lane i occupies bits [2*BIT_DATA*(i+1)-1 : 2*BIT_DATA*i].
REQ-008 SHALL have port in_valid, input, 1 bit: y holds a valid beat.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port bias, input, BIT_ACC*KSIZE bits: packed signed per-lane bias, sampled on the first beat of a vector.
REQ-011 SHALL have port abort, input, 1 bit: early-termination request; discards the vector in progress.
REQ-012 SHALL have port acc_out, output, BIT_ACC*KSIZE bits: packed signed results, same lane order as y.
REQ-013 SHALL have port out_valid, output, 1 bit: acc_out holds a complete vector.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts acc_out.
REQ-015 SHALL have port ovf, output, 1 bit: at least one lane saturated in the current vector.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, ACCUM and HOLD.
REQ-017 SHALL accept a beat only when in_valid && in_ready are both 1.
REQ-018 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-019 SHALL, on an accepted beat in IDLE, load each lane with sat(bias_i + sext(y_i)) and set the beat count to 1.
REQ-020 SHALL, on that first beat, go to HOLD if N_IN == 1, and otherwise go to ACCUM.
REQ-021 SHALL, on an accepted beat in ACCUM, load each lane with sat(acc_i + sext(y_i)) and increment the beat count.
REQ-022 SHALL go to HOLD when the accepted beat is beat number N_IN.
REQ-023 SHALL leave the accumulators and beat count unchanged in cycles with in_valid = 0 (bubbles).
REQ-024 SHALL sign-extend products to BIT_ACC + 1 bits and add them at that width.
REQ-025 SHALL saturate each sum to the range [-2^(BIT_ACC-1), 2^(BIT_ACC-1)-1].
REQ-026 SHALL set the sticky ovf flag whenever any lane clamps, and clear it only on the first beat of a new vector, on abort, or on reset.
REQ-027 SHALL drive out_valid = 1 exactly while in HOLD, starting the cycle after the final beat is accepted.
REQ-028 SHALL hold acc_out and ovf stable while out_valid = 1 and out_ready = 0.
REQ-029 SHALL go from HOLD to IDLE on the cycle where out_valid && out_ready.
REQ-030 SHALL set in_ready = 1 from the next cycle after leaving HOLD; a new vector cannot be accepted in the handoff cycle.
REQ-031 SHALL give abort priority over all other events (except reset) in every state.
REQ-032 SHALL respond to abort by going to IDLE, clearing accumulators, count and ovf, and setting out_valid = 0 on the next cycle.
REQ-033 SHALL discard any beat presented in the same cycle as abort.
REQ-034 SHALL have a latency of 1 cycle from acceptance of the final beat to out_valid = 1.
REQ-035 SHALL support a throughput of one vector per N_IN + 1 cycles when out_ready is held at 1.
REQ-036 SHALL have no combinational path from out_ready to in_ready or from in_valid to any output.

Reset
REQ-037 SHALL, while reset = 1 at a clock edge, enter IDLE with acc_out = 0, beat count = 0, ovf = 0 and out_valid = 0.
REQ-038 SHALL drive in_ready = 1 from the first cycle after reset is deasserted.
REQ-039 SHALL discard any partial vector when reset is asserted mid-vector.
REQ-040 SHALL give reset priority over abort.

Verification (BIT_DATA=8, KSIZE=4, BIT_ACC=20, N_IN=4)
REQ-041 SHALL pass the basic test: bias = 0; 4 consecutive beats with lane i product = i+1 -> acc_out lanes {4, 8, 12, 16}, out_valid = 1 one cycle after the 4th beat, ovf = 0.
REQ-042 SHALL pass the bias and sign test: bias lanes {-100, 0, 50, 7}; every product = -3 for 4 beats -> acc_out lanes {-112, -12, 38, -5}.
REQ-043 SHALL pass the saturation test: bias lane 0 = 524000; lane 0 product = 16384 on each beat -> lane 0 = 524287, ovf = 1; the next vector with bias 0 gives ovf = 0.
REQ-044 SHALL pass the backpressure and bubble test: in_valid toggles 1,0,1,0,... -> results identical to REQ-041; out_ready = 0 for 5 cycles in HOLD -> acc_out stable, in_ready = 0; out_ready = 1 -> IDLE.
REQ-045 SHALL pass the abort test: abort asserted after 2 beats, with in_valid = 1 in that same cycle -> out_valid never asserts; the next vector of REQ-041 stimulus gives {4, 8, 12, 16}.
REQ-046 SHALL pass the reset test: reset asserted for 1 cycle after 3 beats -> all outputs 0, IDLE; a following full vector is correct.

Source files
------------

// File: rtl/dense_accumulator_if.sv
// Beat/result handshake bundle for dense_accumulator.
// master drives beats and consumes results; slave is the accumulator.
interface dense_accumulator_if #(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 4,
  parameter int BIT_ACC  = 20
);
  logic [2*BIT_DATA*KSIZE-1:0] y;
  logic                        in_valid;
  logic                        in_ready;
  logic [BIT_ACC*KSIZE-1:0]    bias;
  logic                        abort;
  logic [BIT_ACC*KSIZE-1:0]    acc_out;
  logic                        out_valid;
  logic                        out_ready;
  logic                        ovf;

  modport master (
    output y, in_valid, bias, abort, out_ready,
    input  in_ready, acc_out, out_valid, ovf
  );

  modport slave (
    input  y, in_valid, bias, abort, out_ready,
    output in_ready, acc_out, out_valid, ovf
  );
endinterface

// File: rtl/dense_accumulator.sv
// Per-lane saturating accumulator over N_IN beats of packed products.
// Result is held in HOLD until downstream takes it.
module dense_accumulator #(
  parameter int BIT_DATA = 8,
  parameter int KSIZE    = 4,
  parameter int BIT_ACC  = 20,
  parameter int N_IN     = 4
) (
  input logic clock,
  input logic reset,
  dense_accumulator_if.slave bus
);
  localparam int PW = 2 * BIT_DATA;
  localparam int W  = BIT_ACC + 1;
  localparam int CW = $clog2(N_IN + 1);

  localparam logic [BIT_ACC-1:0] MAXV =
    {1'b0, {(BIT_ACC-1){1'b1}}};
  localparam logic [BIT_ACC-1:0] MINV =
    {1'b1, {(BIT_ACC-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [BIT_ACC-1:0] acc  [KSIZE];
  logic               ovf_q;

  logic [BIT_ACC-1:0] base [KSIZE];
  logic [PW-1:0]      prod [KSIZE];
  logic [W-1:0]       sum  [KSIZE];
  logic [BIT_ACC-1:0] nxt  [KSIZE];
  logic [KSIZE-1:0]   clamp;

  // First beat starts from bias, later beats from the running sum
  always_comb begin
    clamp = '0;
    for (int i = 0; i < KSIZE; i++) begin
      base[i] = (state == IDLE)
        ? bus.bias[i*BIT_ACC +: BIT_ACC] : acc[i];
      prod[i] = bus.y[i*PW +: PW];
      sum[i]  = {base[i][BIT_ACC-1], base[i]}
              + {{(W-PW){prod[i][PW-1]}}, prod[i]};
      clamp[i] = sum[i][W-1] != sum[i][W-2];
      nxt[i]   = sum[i][BIT_ACC-1:0];
      if (clamp[i])
        nxt[i] = sum[i][W-1] ? MINV : MAXV;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < KSIZE; i++)
        acc[i] <= '0;
    end else if (bus.abort) begin
      state <= IDLE;
      cnt   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < KSIZE; i++)
        acc[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc   <= nxt;
            cnt   <= CW'(1);
            ovf_q <= |clamp;
            state <= (N_IN == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc   <= nxt;
            cnt   <= cnt + CW'(1);
            ovf_q <= ovf_q | (|clamp);
            if (cnt == CW'(N_IN - 1))
              state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.acc_out = '0;
    for (int i = 0; i < KSIZE; i++)
      bus.acc_out[i*BIT_ACC +: BIT_ACC] = acc[i];
  end

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_dense_accumulator.sv
// Bench for dense_accumulator: vector table, corner sequences,
// and random vectors against a saturating-sum reference model.
module tb_dense_accumulator;
  localparam int BD = 8;
  localparam int K  = 4;
  localparam int BA = 20;
  localparam int N  = 4;
  localparam int PW = 2 * BD;
  localparam longint MAXV = (64'sd1 <<< (BA - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (BA - 1));

  typedef logic [K-1:0][31:0] lanes_t;
  typedef logic [N-1:0][K-1:0][31:0] beats_t;

  typedef struct packed {
    lanes_t b;
    lanes_t p;
    lanes_t e;
    logic   ovf;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dense_accumulator_if #(
    .BIT_DATA(BD), .KSIZE(K), .BIT_ACC(BA)
  ) bus ();

  dense_accumulator #(
    .BIT_DATA(BD), .KSIZE(K), .BIT_ACC(BA), .N_IN(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int i);
    return 64'($signed(bus.acc_out[i*BA +: BA]));
  endfunction

  function automatic vec_t mk(
    input int b0, b1, b2, b3,
    input int p0, p1, p2, p3,
    input int e0, e1, e2, e3,
    input bit o);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.ovf = o;
    return v;
  endfunction

  function automatic beats_t flat(input lanes_t p);
    beats_t r;
    for (int j = 0; j < N; j++) r[j] = p;
    return r;
  endfunction

  // Reference: bias plus each product in turn, clamped after every add
  task automatic model(input beats_t p, input lanes_t b,
                       output lanes_t e, output logic o);
    longint a;
    o = 1'b0;
    for (int i = 0; i < K; i++) begin
      a = longint'(int'(b[i]));
      for (int j = 0; j < N; j++) begin
        a = a + longint'(int'(p[j][i]));
        if (a > MAXV) begin a = MAXV; o = 1'b1; end
        if (a < MINV) begin a = MINV; o = 1'b1; end
      end
      e[i] = 32'(a);
    end
  endtask

  task automatic beat(input lanes_t pv, input lanes_t b);
    for (int i = 0; i < K; i++) begin
      bus.y[i*PW +: PW]    = pv[i][PW-1:0];
      bus.bias[i*BA +: BA] = b[i][BA-1:0];
    end
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.y = {$urandom, $urandom};
  endtask

  task automatic junk_bias();
    for (int i = 0; i < K; i++)
      bus.bias[i*BA +: BA] = BA'($urandom);
  endtask

  task automatic run_vec(input string tag, input beats_t p,
                         input lanes_t b, input int gap,
                         input int hold, input lanes_t e,
                         input logic eo);
    lanes_t jb;
    bus.out_ready = (hold == 0);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    for (int j = 0; j < N; j++) begin
      if (j > 0) begin
        for (int g = 0; g < gap; g++) begin
          junk_bias();
          @(posedge clock);
          #1;
        end
      end
      for (int i = 0; i < K; i++) jb[i] = $urandom;
      beat(p[j], (j == 0) ? b : jb);
    end
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < K; i++)
      chk($sformatf("%s lane%0d", tag, i), lane(i),
          64'(int'(e[i])));
    chk({tag, " ovf"}, 64'(bus.ovf), 64'(eo));
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      chk({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, " hold ovf"}, 64'(bus.ovf), 64'(eo));
      for (int i = 0; i < K; i++)
        chk($sformatf("%s hold lane%0d", tag, i), lane(i),
            64'(int'(e[i])));
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, " drained"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " reopen"}, 64'(bus.in_ready), 64'd1);
  endtask

  vec_t   tbl [6];
  vec_t   basic;
  vec_t   sat;
  beats_t rp;
  lanes_t rb;
  lanes_t re;
  logic   ro;
  int     seen;

  initial begin
    tbl[0] = mk(0, 0, 0, 0, 1, 2, 3, 4,
                4, 8, 12, 16, 0);
    tbl[1] = mk(-100, 0, 50, 7, -3, -3, -3, -3,
                -112, -12, 38, -5, 0);
    tbl[2] = mk(524000, 0, 0, 0, 16384, 0, 0, 0,
                524287, 0, 0, 0, 1);
    tbl[3] = mk(0, 0, 0, 0, 1, 1, 1, 1,
                4, 4, 4, 4, 0);
    tbl[4] = mk(0, 0, 0, -524000, 0, 0, 0, -16384,
                0, 0, 0, -524288, 1);
    tbl[5] = mk(524283, -524284, 0, 0, 1, -1, 0, 0,
                524287, -524288, 0, 0, 0);
    basic = tbl[0];
    sat   = tbl[2];

    bus.y = '0;
    bus.bias = '0;
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset ovf", 64'(bus.ovf), 64'd0);
    chk("reset acc_out", 64'(bus.acc_out), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);

    for (int t = 0; t < 6; t++)
      run_vec($sformatf("tbl%0d", t), flat(tbl[t].p), tbl[t].b,
              0, 0, tbl[t].e, tbl[t].ovf);

    run_vec("bubble", flat(basic.p), basic.b, 1, 5,
            basic.e, basic.ovf);

    // Abort mid-vector, with a beat offered in the same cycle
    beat(sat.p, sat.b);
    beat(sat.p, sat.b);
    chk("pre-abort ovf", 64'(bus.ovf), 64'd1);
    for (int i = 0; i < K; i++)
      bus.y[i*PW +: PW] = sat.p[i][PW-1:0];
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort acc_out", 64'(bus.acc_out), 64'd0);
    chk("abort ovf", 64'(bus.ovf), 64'd0);
    chk("abort in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("abort quiet", 64'(seen), 64'd0);
    run_vec("post-abort", flat(basic.p), basic.b, 0, 0,
            basic.e, basic.ovf);

    // Abort while a result is waiting in HOLD
    bus.out_ready = 1'b0;
    for (int j = 0; j < N; j++) beat(basic.p, basic.b);
    chk("hold-abort pre", 64'(bus.out_valid), 64'd1);
    bus.abort = 1'b1;
    @(posedge clock);
    #1;
    bus.abort = 1'b0;
    chk("hold-abort valid", 64'(bus.out_valid), 64'd0);
    chk("hold-abort acc", 64'(bus.acc_out), 64'd0);
    chk("hold-abort in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;

    // Reset mid-vector, with abort also raised
    for (int j = 0; j < 3; j++) beat(basic.p, basic.b);
    reset = 1'b1;
    bus.abort = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.abort = 1'b0;
    chk("mid-reset valid", 64'(bus.out_valid), 64'd0);
    chk("mid-reset acc", 64'(bus.acc_out), 64'd0);
    chk("mid-reset ovf", 64'(bus.ovf), 64'd0);
    chk("mid-reset in_ready", 64'(bus.in_ready), 64'd1);
    run_vec("post-reset", flat(basic.p), basic.b, 0, 0,
            basic.e, basic.ovf);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < K; i++) begin
        if ($urandom_range(0, 3) == 0)
          rb[i] = $urandom_range(0, 1048575) - 524288;
        else
          rb[i] = $urandom_range(0, 2000) - 1000;
        for (int j = 0; j < N; j++)
          rp[j][i] = int'($signed(16'($urandom)));
      end
      model(rp, rb, re, ro);
      run_vec($sformatf("rnd%0d", r), rp, rb,
              $urandom_range(0, 2), $urandom_range(0, 3), re, ro);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule
